btn_gesture_decoder: RTL and testbench
======================================

// Module: btn_gesture_decoder
// PURPOSE
//  Decodes the raw usr_btn pin (active-low) into clean, single-cycle gesture events for board
//  control logic: press/release, short click, double click, long press.
//  Also issues a hold-to-reset request for the board reset pin.
//  Sits between the raw pad and LED/mode/reset logic in top-level designs.
// PARAMETERS
//  DEBOUNCE_CYCLES    48_000      cycles the synced input must be stable to be accepted (1 ms)
//  LONG_CYCLES        24_000_000  debounced hold length that fires long_press (0.5 s)
//  DCLICK_GAP_CYCLES  14_400_000  max released gap for the second click of a double (0.3 s)
//  RESET_HOLD_CYCLES  33_554_432  debounced hold length that asserts reset_req_n (2^25)
//  Legal only when DEBOUNCE_CYCLES >= 2 and LONG_CYCLES < RESET_HOLD_CYCLES; otherwise elaboration error.
// PORTS
//  clk48          in   1  48 MHz system clock; all logic in this domain
//  rst_n          in   1  asynchronous, active-low reset
//  usr_btn        in   1  raw button pin, asynchronous, 0 = pressed
//  btn_level      out  1  debounced level, 1 = pressed
//  press_pulse    out  1  1-cycle strobe on debounced press
//  release_pulse  out  1  1-cycle strobe on debounced release
//  short_click    out  1  1-cycle strobe: single click confirmed (gap expired)
//  double_click   out  1  1-cycle strobe: second click released
//  long_press     out  1  1-cycle strobe: hold reached LONG_CYCLES
//  reset_req_n    out  1  active-low reset request, held low until debounced release
// BEHAVIOUR
//  Reset: sync FFs, stable level = released; btn_level 0; all strobes 0; reset_req_n 1; FSM IDLE; counters 0.
//  Sync: 2-FF synchroniser on ~usr_btn. Debounce: counter clears whenever synced == stable level.
//  Otherwise it increments; at DEBOUNCE_CYCLES-1 the stable level flips and the counter clears.
//  Latency pin->btn_level = 2 + DEBOUNCE_CYCLES cycles. press/release_pulse fire in the same cycle btn_level changes.
//  hold_cnt: clears on press_pulse, increments while pressed, saturates at RESET_HOLD_CYCLES.
//  gap_cnt: clears on release_pulse, increments while released in WAIT_GAP.
//  FSM states IDLE, PRESSED, WAIT_GAP, PRESSED2, HELD:
//   IDLE     : press -> PRESSED
//   PRESSED  : release -> WAIT_GAP; hold_cnt == LONG_CYCLES-1 and still pressed -> long_press, HELD
//   WAIT_GAP : press -> PRESSED2; gap_cnt == DCLICK_GAP_CYCLES-1 -> short_click, IDLE
//   PRESSED2 : release -> double_click, IDLE; long threshold -> long_press, HELD (first click dropped)
//   HELD     : hold_cnt == RESET_HOLD_CYCLES-1 -> reset_req_n 0 (registered, from next cycle);
//              release -> reset_req_n 1 in the cycle of release_pulse, state IDLE
//  Simultaneous events:
//   - release vs long threshold in the same cycle: release wins, no long_press.
//   - press vs gap timeout in the same cycle: press wins, no short_click.
//  At most one gesture strobe (short/double/long) per cycle; strobes never stretch.
//  Reset mid-operation: all outputs return to reset values immediately (async).
//  A button still held after reset deasserts is seen as a fresh press after 2+DEBOUNCE_CYCLES.
//  Counter widths: $clog2(param+1); no wrap, since every counter saturates or clears.
// STRUCTURE
//  Sub-module btn_debounce (sync + debounce, outputs level and press/release strobes).
//  Top holds the FSM and hold/gap counters.
//  Shared header btn_defs.vh: FSM state localparams (3-bit encoding), default timing constants.
// TESTING  (sim params DEBOUNCE=4, LONG=20, DCLICK_GAP=10, RESET_HOLD=40)
//  Glitch: usr_btn low 3 cycles -> btn_level stays 0; no strobes at all.
//  Single click: low 10 cycles, then high -> press_pulse, release_pulse.
//   short_click exactly 10 cycles after release_pulse; no double/long.
//  Double: low 6, high 5, low 6, high -> one double_click at second release_pulse; no short_click.
//  Hold 50 debounced cycles -> long_press at hold_cnt 19.
//   reset_req_n low from hold 40 and back to 1 with release_pulse.
//  Edge cases:
//   - release landing on hold_cnt 19 -> no long_press, FSM WAIT_GAP.
//   - press landing on gap_cnt 9 -> PRESSED2, no short_click.
//  rst_n pulsed low mid-HELD with button held -> reset_req_n 1 and strobes 0 at once.
//   After reset release: press_pulse after 6 cycles, then normal decoding.

Source files
------------

// File: rtl/btn_gesture_decoder_pkg.sv
// Shared definitions for the button gesture decoder: FSM state encoding and
// default timing constants for a 48 MHz clock.
package btn_gesture_decoder_pkg;

  localparam int DEF_DEBOUNCE_CYCLES   = 48_000;
  localparam int DEF_LONG_CYCLES       = 24_000_000;
  localparam int DEF_DCLICK_GAP_CYCLES = 14_400_000;
  localparam int DEF_RESET_HOLD_CYCLES = 33_554_432;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRESSED  = 3'd1,
    WAIT_GAP = 3'd2,
    PRESSED2 = 3'd3,
    HELD     = 3'd4
  } state_t;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus stability counter for the active-low button pad.
// Emits the debounced level and one-cycle press/release strobes aligned to it.
module btn_debounce
  import btn_gesture_decoder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk48,
  input  logic rst_n,
  input  logic usr_btn,
  output logic level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1, sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      sync1         <= 1'b0;
      sync2         <= 1'b0;
      cnt           <= '0;
      level         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      sync1         <= ~usr_btn;
      sync2         <= sync1;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        // strobes are registered with the level so they coincide with its edge
        level         <= sync2;
        cnt           <= '0;
        press_pulse   <= sync2;
        release_pulse <= ~sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/btn_gesture_decoder.sv
// Turns the raw user button into press/release, short/double/long gesture strobes
// and a hold-to-reset request. Gesture strobes appear the cycle after the deciding event.
module btn_gesture_decoder
  import btn_gesture_decoder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES       = DEF_LONG_CYCLES,
  parameter int DCLICK_GAP_CYCLES = DEF_DCLICK_GAP_CYCLES,
  parameter int RESET_HOLD_CYCLES = DEF_RESET_HOLD_CYCLES
) (
  input  logic clk48,
  input  logic rst_n,
  input  logic usr_btn,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_click,
  output logic double_click,
  output logic long_press,
  output logic reset_req_n
);

  if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES >= RESET_HOLD_CYCLES) begin : g_bad_params
    $error("btn_gesture_decoder: illegal timing parameters");
  end

  localparam int HW = $clog2(RESET_HOLD_CYCLES + 1);
  localparam int GW = $clog2(DCLICK_GAP_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(RESET_HOLD_CYCLES);
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] RST_LAST  = HW'(RESET_HOLD_CYCLES - 1);
  localparam logic [GW-1:0] GAP_MAX   = GW'(DCLICK_GAP_CYCLES);
  localparam logic [GW-1:0] GAP_LAST  = GW'(DCLICK_GAP_CYCLES - 1);

  state_t        state;
  logic [HW-1:0] hold_cnt;
  logic [GW-1:0] gap_cnt;
  logic          req_q;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clk48         (clk48),
    .rst_n         (rst_n),
    .usr_btn       (usr_btn),
    .level         (btn_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse)
  );

  // Both counters sit at 0 while the opposite level is held, so each reads 0
  // in the cycle of its starting strobe and n cycles later reads n.
  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
      gap_cnt  <= '0;
    end else begin
      if (!btn_level)              hold_cnt <= '0;
      else if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + HW'(1);
      if (btn_level)               gap_cnt  <= '0;
      else if (gap_cnt != GAP_MAX) gap_cnt  <= gap_cnt + GW'(1);
    end
  end

  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      short_click  <= 1'b0;
      double_click <= 1'b0;
      long_press   <= 1'b0;
      req_q        <= 1'b0;
    end else begin
      short_click  <= 1'b0;
      double_click <= 1'b0;
      long_press   <= 1'b0;
      case (state)
        IDLE:     if (press_pulse) state <= PRESSED;
        PRESSED: begin
          if (release_pulse) state <= WAIT_GAP;
          else if (hold_cnt == LONG_LAST) begin
            long_press <= 1'b1;
            state      <= HELD;
          end
        end
        WAIT_GAP: begin
          if (press_pulse) state <= PRESSED2;
          else if (gap_cnt == GAP_LAST) begin
            short_click <= 1'b1;
            state       <= IDLE;
          end
        end
        PRESSED2: begin
          if (release_pulse) begin
            double_click <= 1'b1;
            state        <= IDLE;
          end else if (hold_cnt == LONG_LAST) begin
            long_press <= 1'b1;
            state      <= HELD;
          end
        end
        HELD: begin
          if (release_pulse) begin
            req_q <= 1'b0;
            state <= IDLE;
          end else if (hold_cnt == RST_LAST) begin
            req_q <= 1'b1;
          end
        end
        default:  state <= IDLE;
      endcase
    end
  end

  // Gating with the debounced level releases the request in the release_pulse cycle.
  assign reset_req_n = ~(req_q & btn_level);

endmodule

// File: tb/tb_btn_gesture_decoder.sv
// Scenario table plus randomized runs, every cycle compared against an
// event-level reference model of the button gestures.
module tb_btn_gesture_decoder;
  localparam int DEB = 4, LONG = 20, GAP = 10, RH = 40;

  logic clk48 = 1'b0, rst_n = 1'b0, usr_btn = 1'b1;
  logic btn_level, press_pulse, release_pulse, short_click, double_click, long_press, reset_req_n;

  btn_gesture_decoder #(
    .DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LONG),
    .DCLICK_GAP_CYCLES(GAP), .RESET_HOLD_CYCLES(RH)
  ) dut (
    .clk48(clk48), .rst_n(rst_n), .usr_btn(usr_btn),
    .btn_level(btn_level), .press_pulse(press_pulse), .release_pulse(release_pulse),
    .short_click(short_click), .double_click(double_click), .long_press(long_press),
    .reset_req_n(reset_req_n)
  );

  always #5 clk48 = ~clk48;

  typedef struct {
    string name;
    int low1, high1, low2;
    int pp, rp, sc, dc, lp, rlow;
  } scen_t;

  int n_vec = 0, n_bad = 0;
  int cyc = 0, c0 = 0;
  bit hist[$];

  bit m_lvl, cur_second;
  int press_t, rel_t, short_due;

  int o_pp, o_rp, o_sc, o_dc, o_lp, o_rrn;
  int t_pp, t_rp, t_sc, t_lp, t_rrn0, t_rrn1;

  task automatic chk(input string nm, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  function automatic bit pin_at(int k);
    if (k < c0) return 1'b0;
    return hist[k];
  endfunction

  function automatic void model_reset();
    m_lvl = 0; cur_second = 0;
    press_t = -1000; rel_t = -1000; short_due = -1;
  endfunction

  // Level follows the pin once it has held the other value for DEB samples (after
  // a 2-flop delay); gestures are classified from press/release timestamps.
  function automatic logic [6:0] model_step(int t);
    bit prev, nw, flip, pp, rp, sc, dc, lp, rrn;
    prev = m_lvl;
    flip = 1'b1;
    for (int k = t - DEB - 2; k <= t - 3; k++)
      if (pin_at(k) == prev) flip = 1'b0;
    nw = flip ? !prev : prev;
    pp = nw && !prev;
    rp = !nw && prev;
    lp = prev && (t - 1 - press_t == LONG - 1);
    dc = (rel_t == t - 1) && cur_second && (rel_t - press_t < LONG);
    sc = (short_due == t);
    if (sc) short_due = -1;
    if (pp) begin
      cur_second = (short_due != -1) && (t - rel_t <= GAP - 1);
      if (cur_second) short_due = -1;
      press_t = t;
    end
    if (rp) begin
      rel_t = t;
      if (t - press_t < LONG && !cur_second) short_due = t + GAP;
    end
    rrn = !(nw && (t - press_t >= RH));
    m_lvl = nw;
    return {nw, pp, rp, sc, dc, lp, rrn};
  endfunction

  task automatic clear_obs();
    o_pp = 0; o_rp = 0; o_sc = 0; o_dc = 0; o_lp = 0; o_rrn = 0;
    t_pp = -1; t_rp = -1; t_sc = -1; t_lp = -1; t_rrn0 = -1; t_rrn1 = -1;
  endtask

  task automatic step(input bit pin);
    logic [6:0] exp, got;
    @(negedge clk48);
    got = {btn_level, press_pulse, release_pulse, short_click, double_click, long_press, reset_req_n};
    if (!rst_n) exp = 7'b0000001;
    else        exp = model_step(cyc);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL cycle %0d outputs {lvl,pp,rp,sc,dc,lp,rrn}: got %b expected %b", cyc, got, exp);
    end
    if (press_pulse === 1'b1)   begin o_pp++; t_pp = cyc; end
    if (release_pulse === 1'b1) begin o_rp++; t_rp = cyc; end
    if (short_click === 1'b1)   begin o_sc++; t_sc = cyc; end
    if (double_click === 1'b1)  o_dc++;
    if (long_press === 1'b1)    begin o_lp++; t_lp = cyc; end
    if (reset_req_n === 1'b0) begin
      if (o_rrn == 0) t_rrn0 = cyc;
      o_rrn++; t_rrn1 = cyc;
    end
    usr_btn = ~pin;
    hist.push_back(pin);
    cyc++;
  endtask

  // Called right after step(), i.e. in the low phase of the clock.
  task automatic set_rst(input bit v);
    logic [6:0] got;
    if (!v) begin
      rst_n = 1'b0;
      #1;
      got = {btn_level, press_pulse, release_pulse, short_click, double_click, long_press, reset_req_n};
      chk("async_reset_outputs", int'(got), 1);
    end else begin
      rst_n = 1'b1;
      c0 = cyc - 1;
      model_reset();
    end
  endtask

  task automatic run_scen(input scen_t s);
    clear_obs();
    repeat (s.low1)  step(1'b1);
    repeat (s.high1) step(1'b0);
    repeat (s.low2)  step(1'b1);
    repeat (40)      step(1'b0);
    chk({s.name, "_press"},   o_pp, s.pp);
    chk({s.name, "_release"}, o_rp, s.rp);
    chk({s.name, "_short"},   o_sc, s.sc);
    chk({s.name, "_double"},  o_dc, s.dc);
    chk({s.name, "_long"},    o_lp, s.lp);
    chk({s.name, "_rstlow"},  o_rrn, s.rlow);
  endtask

  initial begin
    scen_t tbl[11];
    int lo, hi;
    tbl[0]  = '{"glitch",      3,  0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{"single",     10,  0, 0, 1, 1, 1, 0, 0, 0};
    tbl[2]  = '{"double",      6,  5, 6, 2, 2, 0, 1, 0, 0};
    tbl[3]  = '{"gap9",        6,  9, 6, 2, 2, 0, 1, 0, 0};
    tbl[4]  = '{"gap10",       6, 10, 6, 2, 2, 2, 0, 0, 0};
    tbl[5]  = '{"rel_hold19", 19,  0, 0, 1, 1, 1, 0, 0, 0};
    tbl[6]  = '{"long20",     20,  0, 0, 1, 1, 0, 0, 1, 0};
    tbl[7]  = '{"hold41",     41,  0, 0, 1, 1, 0, 0, 1, 1};
    tbl[8]  = '{"hold50",     50,  0, 0, 1, 1, 0, 0, 1, 10};
    tbl[9]  = '{"dbl_long",    6,  5, 25, 2, 2, 0, 0, 1, 0};
    tbl[10] = '{"hi_glitch",   8,  3, 8, 1, 1, 1, 0, 0, 0};

    model_reset();
    clear_obs();
    repeat (3) step(1'b0);
    set_rst(1'b1);
    repeat (10) step(1'b0);

    for (int i = 0; i < 11; i++) run_scen(tbl[i]);

    // single click: short_click lands exactly GAP cycles after release_pulse
    run_scen('{"single_t", 10, 0, 0, 1, 1, 1, 0, 0, 0});
    chk("short_after_release", t_sc - t_rp, GAP);

    // long hold: long_press, reset request window and its release
    run_scen('{"hold50_t", 50, 0, 0, 1, 1, 0, 0, 1, 10});
    chk("long_after_press", t_lp - t_pp, LONG);
    chk("rstlow_start", t_rrn0 - t_pp, RH);
    chk("rstlow_end", t_rrn1, t_rp - 1);

    // reset while HELD with the request active, button kept down
    clear_obs();
    repeat (50) step(1'b1);
    chk("rstreq_before_reset", int'(reset_req_n), 0);
    set_rst(1'b0);
    repeat (3) step(1'b1);
    set_rst(1'b1);
    clear_obs();
    repeat (30) step(1'b1);
    chk("press_after_reset", t_pp - c0, 2 + DEB);
    chk("long_after_reset", o_lp, 1);
    repeat (40) step(1'b0);

    // randomized press/release trains, including sub-debounce glitches
    for (int r = 0; r < 60; r++) begin
      lo = $urandom_range(1, 48);
      hi = $urandom_range(1, 24);
      repeat (lo) step(1'b1);
      repeat (hi) step(1'b0);
    end
    repeat (40) step(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
